// File: rtl/adc_qsys_nios2_gen2_dct_ctrl.sv
// Compressed-trace (DCT) buffer sequencer: packs atoms into words, emits them over valid/ready,
// and runs the end-of-test drain. Optional idle auto-flush is enabled by DCT_TIMEOUT_FLUSH_EN.
module adc_qsys_nios2_gen2_dct_ctrl #(
    parameter int ATOM_W  = 2,
    parameter int SLOTS   = 15,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    atom_valid,
    input  logic [ATOM_W-1:0]       atom_data,
    output logic                    atom_ready,
    input  logic                    flush_req,
    input  logic                    test_ending,
    output logic                    out_valid,
    output logic [SLOTS*ATOM_W-1:0] out_data,
    output logic [3:0]              out_count,
    input  logic                    out_ready,
    output logic [SLOTS*ATOM_W-1:0] dct_buffer,
    output logic [3:0]              dct_count,
    output logic                    test_has_ended,
    output logic [7:0]              atoms_dropped
);
    localparam int         BUF_W   = SLOTS * ATOM_W;
    localparam logic [3:0] SLOTS_C = 4'(SLOTS);

    typedef enum logic [1:0] {FILL, EMIT, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [BUF_W-1:0] buffer_q, buffer_d;
    logic [3:0]       count_q, count_d;
    logic             drain_q, drain_d;
    logic [7:0]       dropped_q, dropped_d;
    logic             accept;
    logic             timeout_hit;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // test_ending blocks acceptance in the same cycle so the drain sees a frozen count
    assign atom_ready = (state_q == FILL) && (count_q < SLOTS_C) && !test_ending;
    assign accept     = atom_valid && atom_ready;

`ifdef DCT_TIMEOUT_FLUSH_EN
    localparam int                IDLE_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    logic [IDLE_W-1:0] idle_q, idle_d;

    always_comb begin
        idle_d      = '0;
        timeout_hit = 1'b0;
        if (state_q == FILL && count_q != 4'd0 && !accept) begin
            if (idle_q == IDLE_LAST) begin
                timeout_hit = 1'b1;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        buffer_d       = buffer_q;
        count_d        = count_q;
        drain_d        = drain_q;
        dropped_d      = dropped_q;
        out_valid      = 1'b0;
        test_has_ended = 1'b0;

        if (atom_valid && (drain_q || test_ending)) begin
            dropped_d = sat_inc8(dropped_q);
        end

        case (state_q)
            FILL: begin
                if (accept) begin
                    for (int i = 0; i < SLOTS; i++) begin
                        if (count_q == 4'(i)) begin
                            buffer_d[i*ATOM_W +: ATOM_W] = atom_data;
                        end
                    end
                    count_d = count_q + 4'd1;
                end
                // Exit decisions use the post-accept count so a same-cycle atom joins the word
                if (test_ending) begin
                    drain_d = 1'b1;
                    state_d = (count_d != 4'd0) ? EMIT : DRAIN;
                end else if (count_d == SLOTS_C ||
                             ((flush_req || timeout_hit) && count_d != 4'd0)) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (test_ending) begin
                    drain_d = 1'b1;
                end
                if (out_ready) begin
                    buffer_d = '0;
                    count_d  = 4'd0;
                    state_d  = (drain_q || test_ending) ? DONE : FILL;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                test_has_ended = 1'b1;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FILL;
            buffer_q  <= '0;
            count_q   <= 4'd0;
            drain_q   <= 1'b0;
            dropped_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            buffer_q  <= buffer_d;
            count_q   <= count_d;
            drain_q   <= drain_d;
            dropped_q <= dropped_d;
        end
    end

    assign out_data      = (state_q == EMIT) ? buffer_q : '0;
    assign out_count     = (state_q == EMIT) ? count_q : 4'd0;
    assign dct_buffer    = buffer_q;
    assign dct_count     = count_q;
    assign atoms_dropped = dropped_q;

endmodule

// File: tb/tb_adc_qsys_nios2_gen2_dct_ctrl.sv
// Self-checking bench for the DCT sequencer: directed scenarios with random atom payloads,
// compared each cycle against a queue-based reference model.
module tb_adc_qsys_nios2_gen2_dct_ctrl;
    localparam int ATOM_W  = 2;
    localparam int SLOTS   = 15;
    localparam int TIMEOUT = 64;
    localparam int BUF_W   = SLOTS * ATOM_W;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             atom_valid;
    logic [1:0]       atom_data;
    logic             atom_ready;
    logic             flush_req;
    logic             test_ending;
    logic             out_valid;
    logic [BUF_W-1:0] out_data;
    logic [3:0]       out_count;
    logic             out_ready;
    logic [BUF_W-1:0] dct_buffer;
    logic [3:0]       dct_count;
    logic             test_has_ended;
    logic [7:0]       atoms_dropped;

    int checks = 0;
    int errors = 0;

    // Reference model: buffered atoms plus the word/drain status flags
    logic [1:0] q[$];
    bit         m_word;
    bit         m_drain;
    bit         m_drain_cyc;
    bit         m_ended;
    int         m_dropped;
`ifdef DCT_TIMEOUT_FLUSH_EN
    int         m_idle;
`endif

    adc_qsys_nios2_gen2_dct_ctrl #(
        .ATOM_W (ATOM_W),
        .SLOTS  (SLOTS),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .atom_valid    (atom_valid),
        .atom_data     (atom_data),
        .atom_ready    (atom_ready),
        .flush_req     (flush_req),
        .test_ending   (test_ending),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_count     (out_count),
        .out_ready     (out_ready),
        .dct_buffer    (dct_buffer),
        .dct_count     (dct_count),
        .test_has_ended(test_has_ended),
        .atoms_dropped (atoms_dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BUF_W-1:0] pack();
        logic [BUF_W-1:0] p = '0;
        for (int i = 0; i < q.size(); i++) p[2*i +: 2] = q[i];
        return p;
    endfunction

    task automatic model_reset();
        q.delete();
        m_word = 0; m_drain = 0; m_drain_cyc = 0; m_ended = 0; m_dropped = 0;
`ifdef DCT_TIMEOUT_FLUSH_EN
        m_idle = 0;
`endif
    endtask

    task automatic model_update();
        bit acc;
        if (atom_valid && (m_drain || test_ending) && m_dropped < 255) m_dropped++;
        if (m_ended) begin
        end else if (m_drain_cyc) begin
            m_drain_cyc = 0;
            m_ended     = 1;
        end else if (m_word) begin
            if (test_ending) m_drain = 1;
            if (out_ready) begin
                q.delete();
                m_word = 0;
                if (m_drain) m_ended = 1;
            end
`ifdef DCT_TIMEOUT_FLUSH_EN
            m_idle = 0;
`endif
        end else if (test_ending) begin
            m_drain = 1;
            if (q.size() > 0) m_word = 1;
            else m_drain_cyc = 1;
`ifdef DCT_TIMEOUT_FLUSH_EN
            m_idle = 0;
`endif
        end else begin
            acc = atom_valid && (q.size() < SLOTS);
            if (acc) q.push_back(atom_data);
            if (q.size() == SLOTS || (flush_req && q.size() > 0)) m_word = 1;
`ifdef DCT_TIMEOUT_FLUSH_EN
            if (acc || q.size() == 0) m_idle = 0;
            else if (m_idle == TIMEOUT - 1) begin m_word = 1; m_idle = 0; end
            else m_idle++;
`endif
        end
    endtask

    task automatic check_outputs();
        logic exp_ready;
        exp_ready = !m_ended && !m_word && !m_drain_cyc && (q.size() < SLOTS) && !test_ending;
        chk("atom_ready", 32'(atom_ready), 32'(exp_ready));
        chk("out_valid", 32'(out_valid), 32'(m_word));
        chk("out_data", 32'(out_data), m_word ? 32'(pack()) : 32'd0);
        chk("out_count", 32'(out_count), m_word ? 32'(q.size()) : 32'd0);
        chk("dct_buffer", 32'(dct_buffer), 32'(pack()));
        chk("dct_count", 32'(dct_count), 32'(q.size()));
        chk("test_has_ended", 32'(test_has_ended), 32'(m_ended));
        chk("atoms_dropped", 32'(atoms_dropped), 32'(m_dropped));
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drv(input logic v, input logic [1:0] d, input logic f,
                       input logic te, input logic r);
        atom_valid = v; atom_data = d; flush_req = f; test_ending = te; out_ready = r;
        step();
    endtask

    task automatic idle_inputs();
        atom_valid = 0; atom_data = 0; flush_req = 0; test_ending = 0; out_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        #1;
        model_reset();
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        int n;
        reset_n = 0;
        idle_inputs();
        #3;
        chk("rst_atom_ready", 32'(atom_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dct_count", 32'(dct_count), 32'd0);
        chk("rst_dct_buffer", 32'(dct_buffer), 32'd0);
        chk("rst_ended", 32'(test_has_ended), 32'd0);
        chk("rst_dropped", 32'(atoms_dropped), 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        model_update();
        #1;

        // Full word of 1,2,3,0,... back-to-back
        for (int i = 0; i < SLOTS; i++) drv(1, 2'((i + 1) % 4), 0, 0, 1);
        chk("t1_word_data", 32'(out_data), 32'h39393939);
        chk("t1_word_count", 32'(out_count), 32'd15);
        for (int i = 0; i < 3; i++) drv(0, 0, 0, 0, 1);

        // Partial word via flush, then flush with an empty buffer
        drv(1, 2'd1, 0, 0, 1); drv(1, 2'd2, 0, 0, 1); drv(1, 2'd3, 0, 0, 1);
        drv(0, 0, 1, 0, 1);
        chk("t2_word_data", 32'(out_data), 32'h39);
        chk("t2_word_count", 32'(out_count), 32'd3);
        for (int i = 0; i < 3; i++) drv(0, 0, 0, 0, 1);
        drv(0, 0, 1, 0, 1);
        chk("t2_empty_flush", 32'(out_valid), 32'd0);
        drv(1, 2'($urandom_range(3, 0)), 1, 0, 1);
        drv(0, 0, 0, 0, 1);

        // Backpressure on a full word
        for (int i = 0; i < SLOTS; i++) drv(1, 2'($urandom_range(3, 0)), 0, 0, 0);
        for (int i = 0; i < 10; i++) drv(1, 2'($urandom_range(3, 0)), 1, 0, 0);
        for (int i = 0; i < 3; i++) drv(1, 2'($urandom_range(3, 0)), 0, 0, 1);

        // Random traffic with flushes and intermittent backpressure
        for (int i = 0; i < 200; i++)
            drv($urandom_range(3, 0) != 0, 2'($urandom_range(3, 0)),
                $urandom_range(19, 0) == 0, 0, $urandom_range(9, 0) < 7);
        for (int i = 0; i < 3; i++) drv(0, 0, 1, 0, 1);

        // Two atoms then idle: auto-flush only when the timeout feature is built in
        drv(1, 2'($urandom_range(3, 0)), 0, 0, 1);
        drv(1, 2'($urandom_range(3, 0)), 0, 0, 1);
        n = 0;
        for (int k = 1; k <= 90; k++) begin
            drv(0, 0, 0, 0, 1);
            if (out_valid && n == 0) n = k;
        end
`ifdef DCT_TIMEOUT_FLUSH_EN
        chk("t6_timeout_latency", 32'(n), 32'd64);
`else
        chk("t6_no_auto_flush", 32'(n), 32'd0);
`endif
        drv(0, 0, 1, 0, 1);
        drv(0, 0, 0, 0, 1);

        // Reset pulse while a word is pending
        for (int i = 0; i < SLOTS; i++) drv(1, 2'($urandom_range(3, 0)), 0, 0, 0);
        chk("t5_pre_valid", 32'(out_valid), 32'd1);
        reset_n = 0;
        #1;
        chk("t5_async_valid", 32'(out_valid), 32'd0);
        chk("t5_async_count", 32'(dct_count), 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        model_update();
        #1;
        drv(1, 2'($urandom_range(3, 0)), 0, 0, 1);
        drv(0, 0, 1, 0, 1);
        drv(0, 0, 0, 0, 1);

        // End-of-test drain with a partial word and atoms still offered
        for (int i = 0; i < 5; i++) drv(1, 2'($urandom_range(3, 0)), 0, 0, 1);
        drv(1, 2'($urandom_range(3, 0)), 0, 1, 1);
        chk("t4_word_count", 32'(out_count), 32'd5);
        for (int i = 0; i < 3; i++) drv(1, 2'($urandom_range(3, 0)), 0, 1, 1);
        for (int i = 0; i < 3; i++) drv(0, 0, 0, 1, 1);
        chk("t4_ended", 32'(test_has_ended), 32'd1);
        chk("t4_dropped", 32'(atoms_dropped), 32'd4);

        // test_ending arrives while a word waits for the store
        do_reset();
        for (int i = 0; i < SLOTS; i++) drv(1, 2'($urandom_range(3, 0)), 0, 0, 0);
        drv(0, 0, 0, 1, 0);
        drv(0, 0, 1, 0, 0);
        drv(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drv(0, 0, 0, 0, 1);
        chk("te_emit_ended", 32'(test_has_ended), 32'd1);

        // Empty drain, then drop counter saturation
        do_reset();
        drv(0, 0, 0, 1, 1);
        drv(0, 0, 0, 1, 1);
        drv(0, 0, 0, 0, 1);
        chk("empty_drain_ended", 32'(test_has_ended), 32'd1);
        for (int i = 0; i < 260; i++) drv(1, 2'($urandom_range(3, 0)), 1, 0, 1);
        drv(0, 0, 0, 0, 1);
        chk("dropped_saturated", 32'(atoms_dropped), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
